// File: rtl/dp_control_unit_pkg.sv
// Shared types and constants for the datapath control unit: FSM states,
// ARM condition codes, ALU opcodes, RSLCT field offsets and the control word.
package dp_control_unit_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH    = 3'd0;
  localparam state_t ST_WAIT_MFC = 3'd1;
  localparam state_t ST_LOAD_IR  = 3'd2;
  localparam state_t ST_INC_PC   = 3'd3;
  localparam state_t ST_DECODE   = 3'd4;
  localparam state_t ST_EXEC     = 3'd5;
  localparam state_t ST_BUS_ERR  = 3'd6;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;
  localparam logic [3:0] OP_CMP_LO = OP_TST;
  localparam logic [3:0] OP_CMP_HI = OP_CMN;

  localparam int RS_RN_OFS  = 0;
  localparam int RS_RM_OFS  = 4;
  localparam int RS_RS_OFS  = 8;
  localparam int RS_RD_OFS  = 12;
  localparam int RS_RN2_OFS = 16;

  typedef struct packed {
    logic        err;
    logic        undef;
    logic        load;
    logic        loadpc;
    logic        ir_cu;
    logic        ir_ld;
    logic        mov;
    logic        rw;
    logic        s;
    logic        alu_out;
    logic [4:0]  op;
    logic [19:0] rslct;
  } ctrl_t;

  // Compare-class ops only set flags; the register file is never written.
  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op >= OP_CMP_LO) && (op <= OP_CMP_HI);
  endfunction

endpackage

// File: rtl/dp_control_unit_cond_eval.sv
// ARM condition-code evaluator; flags are {N,Z,C,V}. Code 1111 never passes.
module cond_eval
  import dp_control_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/dp_control_unit.sv
// Fetch/decode/execute control FSM with registered control outputs.
// DP_COND_EXEC_EN enables conditional execution; otherwise every instruction is AL.
module dp_control_unit
  import dp_control_unit_pkg::*;
#(
  parameter int MFC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  FLAGS,
  output logic [19:0] RSLCT,
  output logic        LOAD,
  output logic        LOADPC,
  output logic        IR_CU,
  output logic        IR_LD,
  output logic        MOV,
  output logic        RW,
  output logic        S,
  output logic        ALU_OUT,
  output logic [4:0]  OP,
  output logic        UNDEF,
  output logic        ERR
);
  localparam int CW = $clog2(MFC_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ir_q;
  logic          start_q, pass_q, cond_pass;
  ctrl_t         ctrl_q, ctrl_d;

`ifdef DP_COND_EXEC_EN
  cond_eval u_cond_eval (.cond(ir_q[31:28]), .flags(FLAGS), .pass(cond_pass));
  logic unused_bits;
  assign unused_bits = ^{ir_q[25], ir_q[7:4]};
`else
  assign cond_pass = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{ir_q[31:28], ir_q[25], ir_q[7:4], FLAGS};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      // start_q holds the FSM for one edge after reset so FETCH is entered cleanly
      ST_FETCH:    state_d = start_q ? ST_WAIT_MFC : ST_FETCH;
      ST_WAIT_MFC: begin
        cnt_d = cnt_q + 1'b1;
        if (MFC)                                 state_d = ST_LOAD_IR;
        else if (cnt_q == CW'(MFC_TIMEOUT - 1)) state_d = ST_BUS_ERR;
      end
      ST_LOAD_IR:  state_d = ST_INC_PC;
      ST_INC_PC:   state_d = ST_DECODE;
      ST_DECODE:   state_d = (pass_q && ir_q[27:26] == 2'b00) ? ST_EXEC : ST_FETCH;
      ST_EXEC:     state_d = ST_FETCH;
      ST_BUS_ERR:  state_d = ST_BUS_ERR;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH, ST_WAIT_MFC: begin
        ctrl_d.mov = 1'b1;
        ctrl_d.rw  = 1'b1;
      end
      ST_LOAD_IR: ctrl_d.ir_ld  = 1'b1;
      ST_INC_PC:  ctrl_d.loadpc = 1'b1;
      ST_DECODE:  ctrl_d.undef  = cond_pass && (ir_q[27:26] != 2'b00);
      ST_EXEC: begin
        ctrl_d.ir_cu   = 1'b1;
        ctrl_d.alu_out = 1'b1;
        ctrl_d.op      = {1'b0, ir_q[24:21]};
        ctrl_d.s       = ir_q[20];
        ctrl_d.load    = !is_cmp_op(ir_q[24:21]);
        ctrl_d.rslct[RS_RN_OFS  +: 4] = ir_q[19:16];
        ctrl_d.rslct[RS_RM_OFS  +: 4] = ir_q[3:0];
        ctrl_d.rslct[RS_RS_OFS  +: 4] = ir_q[11:8];
        ctrl_d.rslct[RS_RD_OFS  +: 4] = ir_q[15:12];
        ctrl_d.rslct[RS_RN2_OFS +: 4] = ir_q[19:16];
      end
      ST_BUS_ERR: ctrl_d.err = 1'b1;
      default:    ctrl_d = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      start_q <= 1'b0;
      cnt_q   <= '0;
      ir_q    <= '0;
      pass_q  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b1;
      cnt_q   <= cnt_d;
      pass_q  <= cond_pass;
      ctrl_q  <= ctrl_d;
      if (ctrl_q.ir_ld) ir_q <= IR;
    end
  end

  assign RSLCT   = ctrl_q.rslct;
  assign LOAD    = ctrl_q.load;
  assign LOADPC  = ctrl_q.loadpc;
  assign IR_CU   = ctrl_q.ir_cu;
  assign IR_LD   = ctrl_q.ir_ld;
  assign MOV     = ctrl_q.mov;
  assign RW      = ctrl_q.rw;
  assign S       = ctrl_q.s;
  assign ALU_OUT = ctrl_q.alu_out;
  assign OP      = ctrl_q.op;
  assign UNDEF   = ctrl_q.undef;
  assign ERR     = ctrl_q.err;
endmodule

// File: tb/tb_dp_control_unit.sv
// Directed bench for dp_control_unit: walks instructions through every FSM state.
module tb_dp_control_unit;
  logic        Clk, RESET, MFC;
  logic [31:0] IR;
  logic [3:0]  FLAGS;
  logic [19:0] RSLCT;
  logic        LOAD, LOADPC, IR_CU, IR_LD, MOV, RW, S, ALU_OUT, UNDEF, ERR;
  logic [4:0]  OP;
  logic [34:0] outs;
  int nvec = 0;
  int nerr = 0;

  dp_control_unit #(.MFC_TIMEOUT(15)) dut (
    .Clk(Clk), .RESET(RESET), .IR(IR), .MFC(MFC), .FLAGS(FLAGS),
    .RSLCT(RSLCT), .LOAD(LOAD), .LOADPC(LOADPC), .IR_CU(IR_CU), .IR_LD(IR_LD),
    .MOV(MOV), .RW(RW), .S(S), .ALU_OUT(ALU_OUT), .OP(OP), .UNDEF(UNDEF), .ERR(ERR)
  );

  assign outs = {ERR, UNDEF, LOAD, LOADPC, IR_CU, IR_LD, MOV, RW, S, ALU_OUT, OP, RSLCT};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Starts and ends in FETCH; MFC rises in WAIT_MFC cycle mfc_at.
  task automatic run(input string nm, input logic [31:0] ir, input logic [3:0] fl,
                     input int mfc_at, input bit ex, input bit ud,
                     input logic [19:0] rs, input logic [4:0] op, input bit s,
                     input bit ld, input bit abort);
    IR = ir; FLAGS = fl; MFC = 1'b0;
    chk({nm, " fetch"}, 64'({MOV, RW, LOAD, ERR}), 64'b1100);
    for (int k = 1; k <= mfc_at; k++) begin
      step();
      chk({nm, " wait"}, 64'({MOV, RW, IR_LD}), 64'b110);
      MFC = (k == mfc_at);
    end
    step(); MFC = 1'b0;
    chk({nm, " load_ir"}, 64'({IR_LD, MOV, LOADPC}), 64'b100);
    step();
    chk({nm, " inc_pc"}, 64'({LOADPC, IR_LD, LOAD}), 64'b100);
    step();
    chk({nm, " decode"}, 64'({UNDEF, LOADPC, LOAD, ALU_OUT, MOV}), 64'({ud, 4'b0000}));
    step();
    if (ex) begin
      chk({nm, " exec"}, 64'({IR_CU, ALU_OUT, LOAD, S, OP, RSLCT}), 64'({2'b11, ld, s, op, rs}));
      if (abort) begin
        RESET = 1'b1; #1;
        chk({nm, " abort"}, 64'(outs), 64'd0);
        #1 RESET = 1'b0;
      end
      step();
    end
    chk({nm, " next"}, 64'({MOV, RW, LOAD, UNDEF, ALU_OUT}), 64'b11000);
  endtask

  initial begin
    RESET = 1'b1; IR = '0; MFC = 1'b0; FLAGS = '0;
    repeat (2) step();
    chk("reset outs", 64'(outs), 64'd0);
    @(negedge Clk) RESET = 1'b0;
    step();

    run("add", 32'hE0812003, 4'b0000, 2, 1, 0, 20'h12031, 5'd4, 0, 1, 0);
    run("cmp", 32'hE1510002, 4'b0000, 1, 1, 0, 20'h10021, 5'd10, 1, 0, 0);
`ifdef DP_COND_EXEC_EN
    run("addeq_fail", 32'h00810003, 4'b0000, 1, 0, 0, 20'h0, 5'd0, 0, 0, 0);
`else
    run("addeq_al", 32'h00810003, 4'b0000, 1, 1, 0, 20'h10031, 5'd4, 0, 1, 0);
`endif
    run("addeq_pass", 32'h00810003, 4'b0100, 1, 1, 0, 20'h10031, 5'd4, 0, 1, 0);
    run("ldr", 32'hE5912000, 4'b0000, 3, 0, 1, 20'h0, 5'd0, 0, 0, 0);
    run("mfc_at_limit", 32'hE0812003, 4'b0000, 15, 1, 0, 20'h12031, 5'd4, 0, 1, 0);

    MFC = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("timeout wait", 64'({MOV, RW, ERR}), 64'b110);
    end
    step();
    chk("bus_err", 64'(outs), 64'({1'b1, 34'd0}));
    repeat (3) step();
    chk("bus_err held", 64'(outs), 64'({1'b1, 34'd0}));
    @(negedge Clk) RESET = 1'b1;
    #1 chk("err cleared", 64'(outs), 64'd0);
    @(negedge Clk) RESET = 1'b0;
    step();

    run("abort_exec", 32'hE0812003, 4'b0000, 1, 1, 0, 20'h12031, 5'd4, 0, 1, 1);
    run("after_abort", 32'hE1510002, 4'b0000, 2, 1, 0, 20'h10021, 5'd10, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
